// File: rtl/to_lower_stream_pkg.sv
// Shared ASCII case constants and the character entry type for the case-conversion stream blocks.
// The to-upper path reuses the same constants (range 97..122, mask ~ASCII_CASE_BIT).
package to_lower_stream_pkg;

  localparam logic [7:0] ASCII_UPPER_A  = 8'd65;
  localparam logic [7:0] ASCII_UPPER_Z  = 8'd90;
  localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } char_entry_t;

  localparam int ENTRY_W = $bits(char_entry_t);

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= ASCII_UPPER_A) && (c <= ASCII_UPPER_Z);
  endfunction

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    return is_upper(c) ? (c | ASCII_CASE_BIT) : c;
  endfunction

endpackage

// File: rtl/to_lower_stream_fifo.sv
// case_sync_fifo: generic DEPTH x WIDTH synchronous FIFO with extra-MSB pointers for full/empty.
// Writes while full and reads while empty are ignored.
module case_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/to_lower_stream.sv
// Streaming ASCII upper-to-lower converter: converts at push, buffers in a small FIFO,
// and keeps saturating byte/conversion counters plus a frame-complete pulse.
module to_lower_stream
  import to_lower_stream_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] conv_cnt,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  char_entry_t wr_entry;
  char_entry_t rd_entry;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  // in_ready comes from registered pointers only, so out_ready never reaches it.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign wr_entry  = '{last: in_last, data: to_lower(in_data)};
  assign out_data  = rd_entry.data;
  assign out_last  = rd_entry.last;

  case_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_entry),
    .full    (full),
    .rd_en   (pop),
    .rd_data (rd_entry),
    .empty   (empty)
  );

  // A clear wins over a same-cycle push; that push is simply not counted.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      byte_cnt <= '0;
      conv_cnt <= '0;
    end else if (push) begin
      if (byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + 1'b1;
      if (is_upper(in_data) && (conv_cnt != CNT_MAX)) conv_cnt <= conv_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) frame_done <= 1'b0;
    else     frame_done <= pop && rd_entry.last;
  end

endmodule

// File: tb/tb_to_lower_stream.sv
// Scenario bench for to_lower_stream: a negedge scoreboard checks every popped byte against
// a reference conversion, while each scenario task checks handshake, counters and frame_done.
module tb_to_lower_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        cnt_clr;
  logic [15:0] byte_cnt;
  logic [15:0] conv_cnt;
  logic        frame_done;

  logic [7:0]  s_in_data;
  logic        s_in_last;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [7:0]  s_out_data;
  logic        s_out_last;
  logic        s_out_valid;
  logic        s_out_ready;
  logic        s_cnt_clr;
  logic [3:0]  s_byte_cnt;
  logic [3:0]  s_conv_cnt;
  logic        s_frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  to_lower_stream #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .byte_cnt(byte_cnt), .conv_cnt(conv_cnt),
    .frame_done(frame_done)
  );

  to_lower_stream #(.DEPTH(2), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_data(s_in_data), .in_last(s_in_last), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .out_data(s_out_data), .out_last(s_out_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .cnt_clr(s_cnt_clr),
    .byte_cnt(s_byte_cnt), .conv_cnt(s_conv_cnt), .frame_done(s_frame_done)
  );

  // Reference conversion written arithmetically: uppercase letters sit 32 below lowercase.
  function automatic logic [8:0] ref_entry(input logic [7:0] d, input logic l);
    logic [7:0] r;
    r = (d >= 8'd65 && d <= 8'd90) ? d + 8'd32 : d;
    return {l, r};
  endfunction

  // Scoreboard: pops compared before the same cycle's push is queued (no bypass exists).
  always @(negedge clk) begin
    logic [8:0] exp;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected_pop: got data=%0d last=%b, nothing expected", out_data, out_last);
        end else begin
          exp = exp_q.pop_front();
          if ({out_last, out_data} !== exp) begin
            n_bad++;
            $display("FAIL sb_pop: got data=%0d last=%b want data=%0d last=%b",
                     out_data, out_last, exp[7:0], exp[8]);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_entry(in_data, in_last));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid until the byte is accepted, then returns 1 time unit after the push edge.
  task automatic send(input logic [7:0] d, input logic l);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: byte %0d never accepted, in_ready=%b", d, in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard     = 0;
    out_ready = 1'b1;
    while (out_valid && guard < 50) begin
      step();
      guard++;
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_timeout: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (byte_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_byte_cnt: got %0d want 0", byte_cnt); end
    n_cmp++; if (conv_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_conv_cnt: got %0d want 0", conv_cnt); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
  endtask

  task automatic test_convert();
    logic [7:0] stim [3];
    logic [7:0] want [3];
    stim = '{8'd65, 8'd90, 8'd72};
    want = '{8'd97, 8'd122, 8'd104};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(stim[i], 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== want[i]) begin
        n_bad++;
        $display("FAIL convert_latency_%0d: got valid=%b data=%0d want valid=1 data=%0d",
                 i, out_valid, out_data, want[i]);
      end
    end
    step();
    n_cmp++; if (conv_cnt !== 16'd3) begin n_bad++; $display("FAIL convert_conv_cnt: got %0d want 3", conv_cnt); end
    n_cmp++; if (byte_cnt !== 16'd3) begin n_bad++; $display("FAIL convert_byte_cnt: got %0d want 3", byte_cnt); end
  endtask

  task automatic test_passthrough();
    logic [7:0] stim [8];
    stim = '{8'd64, 8'd91, 8'd97, 8'd122, 8'd40, 8'd183, 8'd127, 8'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(stim[i], 1'b0);
      n_cmp++;
      if (out_data !== stim[i]) begin
        n_bad++;
        $display("FAIL passthrough_%0d: got %0d want %0d", i, out_data, stim[i]);
      end
    end
    step();
    n_cmp++; if (conv_cnt !== 16'd3) begin n_bad++; $display("FAIL passthrough_conv_cnt: got %0d want 3", conv_cnt); end
    n_cmp++; if (byte_cnt !== 16'd11) begin n_bad++; $display("FAIL passthrough_byte_cnt: got %0d want 11", byte_cnt); end
  endtask

  task automatic test_backpressure();
    drain();
    out_ready = 1'b0;
    send(8'd65, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_1: got %b want 1", in_ready); end
    send(8'd66, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'd67;
    in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready_%0d: got %b want 0", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid_%0d: got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== 8'd97) begin n_bad++; $display("FAIL bp_hold_data_%0d: got %0d want 97", i, out_data); end
      step();
    end
    out_ready = 1'b1;
    send(8'd67, 1'b0);
    send(8'd68, 1'b0);
    drain();
  endtask

  task automatic test_frame();
    out_ready = 1'b1;
    send(8'd65, 1'b0);
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL frame_last_a: got %b want 0", out_last); end
    send(8'd66, 1'b1);
    n_cmp++; if (out_data !== 8'd98 || out_last !== 1'b1) begin
      n_bad++; $display("FAIL frame_head_b: got data=%0d last=%b want 98/1", out_data, out_last); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL frame_done_early: got %b want 0", frame_done); end
    step();
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL frame_done_pulse: got %b want 1", frame_done); end
    step();
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL frame_done_once: got %b want 0", frame_done); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    send(8'd72, 1'b0);
    send(8'd73, 1'b1);
    rst = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (byte_cnt !== 16'd0) begin n_bad++; $display("FAIL midrst_byte_cnt: got %0d want 0", byte_cnt); end
    n_cmp++; if (conv_cnt !== 16'd0) begin n_bad++; $display("FAIL midrst_conv_cnt: got %0d want 0", conv_cnt); end
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_no_emit: got %b want 0", out_valid); end
  endtask

  task automatic test_cnt_clr();
    out_ready = 1'b1;
    send(8'd65, 1'b0);
    n_cmp++; if (byte_cnt !== 16'd1) begin n_bad++; $display("FAIL clr_pre_byte: got %0d want 1", byte_cnt); end
    cnt_clr = 1'b1;
    send(8'd81, 1'b0);
    cnt_clr = 1'b0;
    n_cmp++; if (byte_cnt !== 16'd0) begin n_bad++; $display("FAIL clr_byte_cnt: got %0d want 0", byte_cnt); end
    n_cmp++; if (conv_cnt !== 16'd0) begin n_bad++; $display("FAIL clr_conv_cnt: got %0d want 0", conv_cnt); end
    send(8'd82, 1'b0);
    n_cmp++; if (byte_cnt !== 16'd1) begin n_bad++; $display("FAIL clr_post_byte: got %0d want 1", byte_cnt); end
    n_cmp++; if (conv_cnt !== 16'd1) begin n_bad++; $display("FAIL clr_post_conv: got %0d want 1", conv_cnt); end
    drain();
  endtask

  task automatic test_saturation();
    int acc;
    int guard;
    acc   = 0;
    guard = 0;
    s_out_ready = 1'b1;
    s_in_data   = 8'd90;
    s_in_valid  = 1'b1;
    while (acc < 20 && guard < 100) begin
      @(negedge clk);
      if (s_in_ready) acc++;
      if (acc == 15) begin
        step();
        n_cmp++; if (s_byte_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_reach_byte: got %0d want 15", s_byte_cnt); end
      end else begin
        step();
      end
      guard++;
    end
    s_in_valid = 1'b0;
    n_cmp++; if (acc != 20) begin n_bad++; $display("FAIL sat_accepts: got %0d want 20", acc); end
    step();
    n_cmp++; if (s_byte_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_byte_cnt: got %0d want 15", s_byte_cnt); end
    n_cmp++; if (s_conv_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_conv_cnt: got %0d want 15", s_conv_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    in_data     = '0;
    in_last     = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    cnt_clr     = 1'b0;
    s_in_data   = '0;
    s_in_last   = 1'b0;
    s_in_valid  = 1'b0;
    s_out_ready = 1'b0;
    s_cnt_clr   = 1'b0;

    test_reset();
    test_convert();
    test_passthrough();
    test_backpressure();
    test_frame();
    test_reset_midstream();
    test_cnt_clr();
    test_saturation();
    drain();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d undelivered bytes want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
